icache_dm: RTL and testbench

ICACHE_DM -- requirements
Module: icache_dm

---
 rtl/cpu_types_pkg.sv | 28 ++
 rtl/icache_dm_if.sv | 25 ++
 rtl/icache_dm.sv | 98 +++++++++
 tb/tb_icache_dm.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the direct-mapped instruction cache: machine word, the
// default-geometry (16-frame) address split and frame layout, and FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Default geometry: 16 one-word frames -> 4 index bits, 26 tag bits.
  localparam int ICACHE_IDX_W = 4;
  localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icachef_t;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    word_t                   data;
  } iframe_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } istate_t;

endpackage

// File: rtl/icache_dm_if.sv
// Datapath-side and memory-side signals of the instruction cache.
// slave: the cache's view; master: the datapath/memory environment.
interface icache_dm_if;
  import cpu_types_pkg::*;

  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  logic  iwait;
  word_t iload;
  logic  iREN;
  word_t iaddr;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );

endinterface

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with one-word frames. A miss in IDLE
// latches the address and moves to FETCH, which holds the memory read until
// iwait drops, fills the frame and returns to IDLE. Hit/miss counters wrap.
module icache_dm
  import cpu_types_pkg::*;
#(
  parameter int NSETS = 16,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  icache_dm_if.slave       bus,
  output logic [CNT_W-1:0] hitcnt,
  output logic [CNT_W-1:0] misscnt
);

  // Address split re-derived from NSETS so non-default geometries work.
  localparam int IDX_W = $clog2(NSETS);
  localparam int TAG_W = 30 - IDX_W;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [1:0]       bytoff;
  } addr_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    word_t            data;
  } frame_t;

  istate_t          state_q;
  addr_t            miss_q;
  addr_t            req_a;
  frame_t           frames_q [NSETS];
  frame_t           req_fr;
  logic [CNT_W-1:0] hitcnt_q, hitcnt_d;
  logic [CNT_W-1:0] misscnt_q, misscnt_d;
  logic             hit, miss, fill;
  logic             unused_bytoff;

  assign req_a         = addr_t'(bus.imemaddr);
  assign req_fr        = frames_q[req_a.idx];
  assign unused_bytoff = ^req_a.bytoff;

  // Lookup is combinational and only live in IDLE outside reset.
  assign hit  = !RST && (state_q == IDLE) && bus.imemREN && req_fr.valid &&
                (req_fr.tag == req_a.tag);
  assign miss = (state_q == IDLE) && bus.imemREN && !hit;
  assign fill = (state_q == FETCH) && !bus.iwait;

  assign hitcnt_d  = hit  ? hitcnt_q  + CNT_W'(1) : hitcnt_q;
  assign misscnt_d = miss ? misscnt_q + CNT_W'(1) : misscnt_q;

  assign bus.ihit     = hit;
  assign bus.imemload = req_fr.data;
  assign bus.iREN     = (state_q == FETCH);
  assign bus.iaddr    = (state_q == FETCH) ? word_t'(miss_q) : '0;
  assign hitcnt       = hitcnt_q;
  assign misscnt      = misscnt_q;

  // Control FSM: miss capture, fetch wait, and performance counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      miss_q    <= '0;
      hitcnt_q  <= '0;
      misscnt_q <= '0;
    end else begin
      hitcnt_q  <= hitcnt_d;
      misscnt_q <= misscnt_d;
      case (state_q)
        IDLE: begin
          if (miss) begin
            miss_q  <= req_a;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          if (fill) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Frame store: reset clears only valid bits (an in-flight fill is dropped);
  // a fill overwrites whatever frame sits at the latched index.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NSETS; i++) frames_q[IDX_W'(i)].valid <= 1'b0;
    end else if (fill) begin
      frames_q[miss_q.idx] <= '{valid: 1'b1, tag: miss_q.tag, data: bus.iload};
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm: directed scenarios followed by a random phase, all
// checked every cycle against a frame-table reference model.
module tb_icache_dm;
  import cpu_types_pkg::*;

  localparam int          NSETS = 16;
  localparam int          CNT_W = 4;
  localparam int unsigned CMOD  = 1 << CNT_W;

  logic             CLK = 1'b0;
  logic             RST;
  logic [CNT_W-1:0] hitcnt, misscnt;

  icache_dm_if bus ();

  icache_dm #(.NSETS(NSETS), .CNT_W(CNT_W)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .bus    (bus),
    .hitcnt (hitcnt),
    .misscnt(misscnt)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit          m_known = 1'b0;
  bit          m_fetch = 1'b0;
  word_t       m_maddr = '0;
  int unsigned m_hit   = 0;
  int unsigned m_miss  = 0;
  bit          m_v   [NSETS];
  word_t       m_tag [NSETS];
  word_t       m_dat [NSETS];

  // Outputs sampled in the last cycle
  logic             o_ihit, o_iren;
  word_t            o_load, o_iaddr;
  logic [CNT_W-1:0] o_hc, o_mc;

  function automatic int unsigned idx_of(word_t a);
    return (a / 4) % NSETS;
  endfunction

  function automatic word_t tag_of(word_t a);
    return a / (4 * NSETS);
  endfunction

  function automatic bit model_hit();
    int unsigned ix;
    ix = idx_of(bus.imemaddr);
    return !RST && !m_fetch && bus.imemREN && m_v[ix] &&
           (m_tag[ix] == tag_of(bus.imemaddr));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic rst, input logic ren, input word_t a,
                     input logic w, input word_t ld);
    RST          = rst;
    bus.imemREN  = ren;
    bus.imemaddr = a;
    bus.iwait    = w;
    bus.iload    = ld;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    bit          eh;
    int unsigned ix;
    @(negedge CLK);
    o_ihit  = bus.ihit;
    o_iren  = bus.iREN;
    o_load  = bus.imemload;
    o_iaddr = bus.iaddr;
    o_hc    = hitcnt;
    o_mc    = misscnt;
    eh      = model_hit();
    if (m_known) begin
      chk("ihit", 32'(o_ihit), 32'(eh));
      if (eh) chk("imemload", o_load, m_dat[idx_of(bus.imemaddr)]);
      chk("iREN", 32'(o_iren), 32'(m_fetch));
      chk("iaddr", o_iaddr, m_fetch ? m_maddr : 32'h0);
      chk("hitcnt", 32'(o_hc), m_hit % CMOD);
      chk("misscnt", 32'(o_mc), m_miss % CMOD);
    end else if (RST) begin
      chk("ihit_in_reset", 32'(o_ihit), 32'h0);
    end
    @(posedge CLK);
    if (RST) begin
      m_known = 1'b1;
      m_fetch = 1'b0;
      m_maddr = '0;
      m_hit   = 0;
      m_miss  = 0;
      for (int i = 0; i < NSETS; i++) m_v[i] = 1'b0;
    end else if (m_known) begin
      if (!m_fetch) begin
        if (bus.imemREN) begin
          if (eh) m_hit++;
          else begin
            m_miss++;
            m_maddr = bus.imemaddr;
            m_fetch = 1'b1;
          end
        end
      end else if (!bus.iwait) begin
        ix        = idx_of(m_maddr);
        m_v[ix]   = 1'b1;
        m_tag[ix] = tag_of(m_maddr);
        m_dat[ix] = bus.iload;
        m_fetch   = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    drv(1'b1, 1'b0, 32'h0, 1'b1, 32'h0);
    cycle();
    cycle();
    drv(1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    cycle();
    chk("rst_ihit", 32'(o_ihit), 32'h0);
    chk("rst_iREN", 32'(o_iren), 32'h0);
    chk("rst_iaddr", o_iaddr, 32'h0);
    chk("rst_hitcnt", 32'(o_hc), 32'h0);
    chk("rst_misscnt", 32'(o_mc), 32'h0);

    // Cold miss on 0x40
    drv(1'b0, 1'b1, 32'h40, 1'b1, 32'h0);
    cycle();
    chk("cold_ihit0", 32'(o_ihit), 32'h0);
    cycle();
    chk("cold_iREN", 32'(o_iren), 32'h1);
    chk("cold_iaddr", o_iaddr, 32'h40);
    drv(1'b0, 1'b1, 32'h40, 1'b0, 32'h2001_0005);
    cycle();
    drv(1'b0, 1'b1, 32'h40, 1'b1, 32'h0);
    cycle();
    chk("cold_ihit1", 32'(o_ihit), 32'h1);
    chk("cold_load", o_load, 32'h2001_0005);
    chk("cold_misscnt", 32'(o_mc), 32'h1);

    // Hit streak: the cycle above was the first of three hits
    cycle();
    chk("streak_iREN", 32'(o_iren), 32'h0);
    cycle();
    chk("streak_ihit", 32'(o_ihit), 32'h1);
    drv(1'b0, 1'b0, 32'h40, 1'b1, 32'h0);
    cycle();
    chk("streak_hitcnt", 32'(o_hc), 32'h3);

    // Conflict: 0x440 evicts 0x40
    drv(1'b0, 1'b1, 32'h440, 1'b1, 32'h0);
    cycle();
    chk("conf_miss440", 32'(o_ihit), 32'h0);
    drv(1'b0, 1'b1, 32'h440, 1'b0, 32'hAAAA_0440);
    cycle();
    drv(1'b0, 1'b1, 32'h440, 1'b1, 32'h0);
    cycle();
    chk("conf_hit440", 32'(o_ihit), 32'h1);
    chk("conf_load440", o_load, 32'hAAAA_0440);
    drv(1'b0, 1'b1, 32'h40, 1'b1, 32'h0);
    cycle();
    chk("conf_remiss40", 32'(o_ihit), 32'h0);
    drv(1'b0, 1'b1, 32'h40, 1'b0, 32'h2001_0005);
    cycle();
    drv(1'b0, 1'b0, 32'h40, 1'b1, 32'h0);
    cycle();
    chk("conf_misscnt", 32'(o_mc), 32'h3);

    // Address change during FETCH
    drv(1'b0, 1'b1, 32'h80, 1'b1, 32'h0);
    cycle();
    drv(1'b0, 1'b1, 32'h84, 1'b1, 32'h0);
    cycle();
    chk("chg_iaddr", o_iaddr, 32'h80);
    chk("chg_ihit", 32'(o_ihit), 32'h0);
    drv(1'b0, 1'b1, 32'h84, 1'b0, 32'h1111_0080);
    cycle();
    drv(1'b0, 1'b1, 32'h84, 1'b1, 32'h0);
    cycle();
    chk("chg_miss84", 32'(o_ihit), 32'h0);
    chk("chg_idle_iREN", 32'(o_iren), 32'h0);
    drv(1'b0, 1'b1, 32'h84, 1'b0, 32'h2222_0084);
    cycle();
    chk("chg_iaddr84", o_iaddr, 32'h84);
    drv(1'b0, 1'b1, 32'h80, 1'b1, 32'h0);
    cycle();
    chk("chg_hit80", 32'(o_ihit), 32'h1);
    chk("chg_load80", o_load, 32'h1111_0080);

    // Memory stall of 10 cycles on 0xC0 with noisy datapath inputs
    drv(1'b0, 1'b1, 32'hC0, 1'b1, 32'h0);
    cycle();
    for (int k = 0; k < 10; k++) begin
      drv(1'b0, 1'($urandom_range(0, 1)), word_t'($urandom), 1'b1, word_t'($urandom));
      cycle();
      chk("stall_iREN", 32'(o_iren), 32'h1);
      chk("stall_iaddr", o_iaddr, 32'hC0);
      chk("stall_ihit", 32'(o_ihit), 32'h0);
      chk("stall_hitcnt", 32'(o_hc), 32'h5);
      chk("stall_misscnt", 32'(o_mc), 32'h6);
    end

    // Reset while still in FETCH
    drv(1'b1, 1'b1, 32'hC0, 1'b1, 32'h0);
    cycle();
    drv(1'b0, 1'b0, 32'hC0, 1'b1, 32'h0);
    cycle();
    chk("rstf_iREN", 32'(o_iren), 32'h0);
    chk("rstf_hitcnt", 32'(o_hc), 32'h0);
    chk("rstf_misscnt", 32'(o_mc), 32'h0);
    drv(1'b0, 1'b1, 32'hC0, 1'b1, 32'h0);
    cycle();
    chk("rstf_missC0", 32'(o_ihit), 32'h0);
    drv(1'b0, 1'b1, 32'hC0, 1'b0, 32'h3333_3333);
    cycle();

    // Counter wrap: 17 hits on a 4-bit counter leave it at 1
    drv(1'b0, 1'b1, 32'hC2, 1'b1, 32'h0);
    repeat (17) cycle();
    drv(1'b0, 1'b0, 32'hC0, 1'b1, 32'h0);
    cycle();
    chk("wrap_hitcnt", 32'(o_hc), 32'h1);
    drv(1'b0, 1'b1, 32'h40, 1'b1, 32'h0);
    cycle();
    chk("rstf_miss40", 32'(o_ihit), 32'h0);
    drv(1'b0, 1'b1, 32'h40, 1'b0, 32'h4444_0040);
    cycle();

    // Random traffic over a small address pool so hits, conflicts and wraps occur
    for (int k = 0; k < 800; k++) begin
      word_t a;
      word_t tg;
      case ($urandom_range(0, 2))
        0:       tg = 32'h0;
        1:       tg = 32'h1;
        default: tg = 32'h03FF_FFFF;
      endcase
      a = (tg << 6) | (word_t'($urandom_range(0, 7)) << 2) | word_t'($urandom_range(0, 3));
      drv(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) != 0), a,
          1'($urandom_range(0, 2) == 0), word_t'($urandom));
      cycle();
    end

    drv(1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    cycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
